// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, status bit positions and FSM encoding for the
// memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_BASE = 32'h0000_1000;

  // Word index within the register window (a[3:2]).
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_BAUD   = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A zero divider would never finish a bit, so it is promoted to 1.
  function automatic logic [15:0] baud_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  function automatic logic [3:0] count_sat(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is presented combinationally.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Same slot but different lap means the writer is a full buffer ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on the
// data-memory bus, a byte FIFO and a start/data/stop serialiser.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = UART_BASE,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus handshake: a store is a single-cycle strobe (we) with no back-pressure.
  // A TXDATA store is taken when the FIFO is not full; otherwise it is dropped
  // and overflow is latched until software writes STATUS.
  logic [1:0] reg_idx;
  logic       txdata_wr;
  logic       status_wr;
  logic       baud_wr;

  assign reg_idx   = a[3:2];
  assign sel       = (a[31:4] == BASE_ADDR[31:4]) && (reg_idx != 2'b11);
  assign txdata_wr = we && sel && (reg_idx == UART_TXDATA);
  assign status_wr = we && sel && (reg_idx == UART_STATUS);
  assign baud_wr   = we && sel && (reg_idx == UART_BAUD);

  logic unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:16]};

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_count_ext;

  assign fifo_push      = txdata_wr && !fifo_full;
  assign fifo_count_ext = 32'(fifo_count);

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic        overflow;
  logic [15:0] baud_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      baud_div <= baud_sanitize(CLKS_PER_BIT);
    end else begin
      if (txdata_wr && fifo_full) overflow <= 1'b1;
      else if (status_wr)         overflow <= 1'b0;
      if (baud_wr) baud_div <= baud_sanitize(wd[15:0]);
    end
  end

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;
  logic        bit_done;
  logic        empty_next;

  assign bit_done = (cnt_q == frame_div_q - 16'd1);

  logic [31:0] status;
  always_comb begin
    status                           = '0;
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_BUSY]                  = (state_q != S_IDLE);
    status[ST_OVF]                   = overflow;
    status[ST_CNT_LSB+3:ST_CNT_LSB]  = count_sat(fifo_count_ext);
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (reg_idx)
        UART_STATUS: rd = status;
        UART_BAUD:   rd = {16'h0000, baud_div};
        default:     rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_div_q <= 16'd1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      irq_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_div_q <= frame_div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_div_d = frame_div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    txd_d       = txd_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_dout;
          frame_div_d = baud_div;
          cnt_d       = '0;
          txd_d       = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d     = '0;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so frames stay gapless.
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_d     = fifo_dout;
            frame_div_d = baud_div;
            txd_d       = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    empty_next = (fifo_empty && !fifo_push) ||
                 ((fifo_count_ext == 32'd1) && fifo_pop && !fifo_push);
    irq_d      = (state_d == S_IDLE) && empty_next;
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus: the same we/a/wd/rd signals that drive dmem.
- Consumes CPU store traffic: a byte stored to TXDATA is buffered in a FIFO and serialised 8N1 on txd.
- Exposes a status register and a baud divider register. The top level muxes rd into the core's read data whenever sel is high.
- Gives programs a serial output path alongside the led port.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 3-register window.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, ≥ 2.
- CLKS_PER_BIT, 16'd868, reset value of BAUDDIV (100 MHz / 115200).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  store strobe (MemWrite).
- a  in  32  byte address (ALUResult / ALUResultM).
- wd  in  32  store data (WriteData).
- rd  out  32  combinational read data; 0 when sel=0.
- sel  out  1  combinational; 1 when a[31:4]==BASE_ADDR[31:4] and a[3:2]!=2'b11.
- txd  out  1  serial output, registered, idle high.
- irq  out  1  registered; 1 when the FIFO is empty and the FSM is IDLE.

Behaviour:

Register map (compare a[31:2]; a[1:0] ignored):
- +0x0 TXDATA: write pushes wd[7:0]; reads as 0.
- +0x4 STATUS, read:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM != IDLE)
  - bit3 overflow, sticky
  - bits[7:4] FIFO count, saturating at 15
  - all other bits 0
- +0x4 STATUS, write: any write clears overflow.
- +0x8 BAUDDIV: r/w, 16 bits in [15:0]. A write of 0 is stored as 1. Upper bits read 0.

Reset (asynchronous, applies immediately, including mid-frame):
- FIFO emptied; overflow=0; BAUDDIV=CLKS_PER_BIT.
- FSM=IDLE; txd=1; irq=1; rd follows its combinational definition.

Push:
- Occurs on a clock edge when we=1, TXDATA is selected and full=0.
- If full=1, the byte is dropped and overflow is set. Full is the pre-edge value; a same-cycle pop does not make room.

FSM states: IDLE, START, DATA, STOP. Counters: baud cnt[15:0], bit idx[2:0].
- IDLE:
  - If FIFO non-empty: pop the head into an 8-bit shift register, latch BAUDDIV into frame_div, go to START.
  - txd is 0 from that edge onward.
  - Latency: a push at edge E0 gives txd falling at E1.
- START: hold txd=0 for frame_div cycles, then go to DATA with txd=shift[0].
- DATA:
  - Each bit is held frame_div cycles, LSB first.
  - After bit 7, go to STOP with txd=1.
- STOP: txd=1 for frame_div cycles, then:
  - FIFO non-empty: pop and go straight to START. No idle gap; back-to-back frames are exactly 10*frame_div cycles apart.
  - FIFO empty: go to IDLE.
- A BAUDDIV write mid-frame takes effect at the next frame only.

Other rules:
- Pop happens only in the IDLE→START and STOP→START transitions. Pop and push in the same cycle are both legal when not full; count is then unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full and empty come from the MSB compare.
- Writes to offset 0xC are outside the window (sel=0) and ignored.

Decomposition:
- config.vh gains:
  - `UART_BASE
  - register offsets UART_TXDATA=0, UART_STATUS=1, UART_BAUD=2 (word index)
  - STATUS bit positions
  - FSM state localparams, 2-bit encoding
- One sub-module, fifo_sync (parameters WIDTH=8, DEPTH):
  - ports clk, reset, push, pop, din, dout (head, combinational), full, empty, count.
- Top-level read mux: rd_core = sel ? uart_rd : dmem_rd. This is a separate change to top.

Test Plan:
1. Reset, then read STATUS and BAUDDIV: STATUS=0x02, BAUDDIV=868, txd=1, irq=1.
2. BAUDDIV=4; store 0xA5 to TXDATA at edge E0:
   - txd=0 for cycles E1..E4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
   - irq returns to 1 at E41.
3. BAUDDIV=2; store 0x55 then 0x0F on consecutive cycles:
   - two frames, start bits exactly 20 cycles apart, no idle cycle between.
   - STATUS count reads 1 during the first frame.
4. BAUDDIV=1; store 10 bytes back-to-back:
   - bytes 1-9 accepted: 1 popped immediately plus 8 buffered, so full=1.
   - 10th dropped, overflow=1.
   - Writing STATUS clears overflow; the serialised bytes match the first 9 in order.
5. Mid-frame: assert reset during DATA:
   - txd=1 and STATUS=0x02 immediately, without waiting for a clock edge.
   - No further frame after deassert.
6. Write BAUDDIV=0, read it back as 1. Store to address 0x100C: sel=0 and no state change.
